umi_endpoint: RTL and testbench

UMI_ENDPOINT -- requirements
Module: umi_endpoint

---
 rtl/umi_endpoint.sv | 254 +++++++++++++++++++++++++
 tb/tb_umi_endpoint.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/umi_endpoint.sv
// umi_endpoint: UMI request endpoint bridging packets onto a simple local bus.
// Optional dropped-command counter enabled by defining UMI_ENDPOINT_ERRCNT_EN.
module umi_unpack #(
  parameter int AW = 64,
  parameter int PW = 256,
  parameter int DW = 64
) (
  input  logic [PW-1:0] packet,
  output logic          cmd_read,
  output logic          cmd_write,
  output logic          cmd_write_ack,
  output logic          cmd_atomic,
  output logic          cmd_invalid,
  output logic [3:0]    cmd_size,
  output logic [19:0]   cmd_user,
  output logic [AW-1:0] dstaddr,
  output logic [AW-1:0] srcaddr,
  output logic [DW-1:0] data
);
  // Opcodes: 00 invalid, 01 read, 03 posted write, 05 acked write,
  // x9 atomic; anything else is an unsupported command.
  logic [7:0]  op;
  logic [63:0] dst64;
  logic [63:0] src64;
  logic [63:0] dat64;
  logic        unused_pad;

  assign op            = packet[7:0];
  assign cmd_invalid   = (op == 8'h00);
  assign cmd_read      = (op == 8'h01);
  assign cmd_write     = (op == 8'h03) | (op == 8'h05);
  assign cmd_write_ack = (op == 8'h05);
  assign cmd_atomic    = (op[3:0] == 4'h9);
  assign cmd_size      = packet[11:8];
  assign cmd_user      = packet[31:12];

  assign dst64 = {packet[255:224], packet[63:32]};
  assign src64 = {packet[223:192], packet[95:64]};
  assign dat64 = packet[159:96];

  assign dstaddr = dst64[AW-1:0];
  assign srcaddr = src64[AW-1:0];
  assign data    = dat64[DW-1:0];

  assign unused_pad = ^packet[191:160];
endmodule

module umi_endpoint #(
  parameter int         AW      = 64,
  parameter int         PW      = 256,
  parameter int         DW      = 64,
  parameter logic [7:0] RESP_OP = 8'h02
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          umi_in_valid,
  input  logic [PW-1:0] umi_in_packet,
  output logic          umi_in_ready,
  output logic          umi_out_valid,
  output logic [PW-1:0] umi_out_packet,
  input  logic          umi_out_ready,
  output logic [AW-1:0] loc_addr,
  output logic          loc_write,
  output logic          loc_read,
  output logic [DW-1:0] loc_wrdata,
  input  logic [DW-1:0] loc_rddata,
  input  logic          loc_ready,
  output logic [15:0]   err_count
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic          cmd_read;
  logic          cmd_write;
  logic          cmd_write_ack;
  logic          cmd_atomic;
  logic          cmd_invalid;
  logic [3:0]    cmd_size;
  logic [19:0]   cmd_user;
  logic [AW-1:0] dstaddr;
  logic [AW-1:0] srcaddr;
  logic [DW-1:0] data;

  logic [AW-1:0] addr_q;
  logic [AW-1:0] src_q;
  logic [DW-1:0] data_q;
  logic [3:0]    size_q;
  logic [19:0]   user_q;
  logic          rd_q;
  logic          ack_q;
  logic [PW-1:0] resp_q;
  logic [PW-1:0] resp_d;

  logic cap_req;
  logic cap_rsp;
  logic drop;
  logic unused_dec;

  umi_unpack #(
    .AW(AW),
    .PW(PW),
    .DW(DW)
  ) u_unpack (
    .packet       (umi_in_packet),
    .cmd_read     (cmd_read),
    .cmd_write    (cmd_write),
    .cmd_write_ack(cmd_write_ack),
    .cmd_atomic   (cmd_atomic),
    .cmd_invalid  (cmd_invalid),
    .cmd_size     (cmd_size),
    .cmd_user     (cmd_user),
    .dstaddr      (dstaddr),
    .srcaddr      (srcaddr),
    .data         (data)
  );

  // Atomics and invalids fall into the generic drop path.
  assign unused_dec = cmd_atomic ^ cmd_invalid;

  // Next state, handshakes and local strobes.
  always_comb begin
    state_d       = state_q;
    umi_in_ready  = 1'b0;
    umi_out_valid = 1'b0;
    loc_read      = 1'b0;
    loc_write     = 1'b0;
    cap_req       = 1'b0;
    cap_rsp       = 1'b0;
    drop          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        umi_in_ready = 1'b1;
        if (umi_in_valid) begin
          if (cmd_read | cmd_write) begin
            cap_req = 1'b1;
            state_d = S_ACCESS;
          end else begin
            drop = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        loc_read  = rd_q;
        loc_write = ~rd_q;
        if (loc_ready) begin
          if (rd_q | ack_q) begin
            cap_rsp = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_RESP: begin
        umi_out_valid = 1'b1;
        if (umi_out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Response packet: source/destination swapped back to the requester.
  always_comb begin
    logic [63:0] s64;
    logic [63:0] d64;
    logic [63:0] r64;
    s64 = 64'(src_q);
    d64 = 64'(addr_q);
    r64 = rd_q ? 64'(loc_rddata) : 64'h0;
    resp_d            = '0;
    resp_d[7:0]       = RESP_OP;
    resp_d[11:8]      = size_q;
    resp_d[31:12]     = user_q;
    resp_d[63:32]     = s64[31:0];
    resp_d[255:224]   = s64[63:32];
    resp_d[95:64]     = d64[31:0];
    resp_d[223:192]   = d64[63:32];
    resp_d[159:96]    = r64;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request fields and held response.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      addr_q <= '0;
      src_q  <= '0;
      data_q <= '0;
      size_q <= '0;
      user_q <= '0;
      rd_q   <= 1'b0;
      ack_q  <= 1'b0;
      resp_q <= '0;
    end else begin
      if (cap_req) begin
        addr_q <= dstaddr;
        src_q  <= srcaddr;
        data_q <= data;
        size_q <= cmd_size;
        user_q <= cmd_user;
        rd_q   <= cmd_read;
        ack_q  <= cmd_write_ack;
      end
      if (cap_rsp) begin
        resp_q <= resp_d;
      end
    end
  end

  assign loc_addr       = addr_q;
  assign loc_wrdata     = data_q;
  assign umi_out_packet = resp_q;

`ifdef UMI_ENDPOINT_ERRCNT_EN
  logic [15:0] err_q, err_d;

  // Saturating count of dropped commands.
  always_comb begin
    err_d = err_q;
    if (drop && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      err_q <= 16'h0000;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_count = err_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign err_count   = 16'h0000;
`endif
endmodule

// File: tb/tb_umi_endpoint.sv
// tb_umi_endpoint: directed table plus randomized transactions for umi_endpoint.
// Expected packets come from a field-level model of the response layout.
module tb_umi_endpoint;
  localparam int AW = 64;
  localparam int PW = 256;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          umi_in_valid = 1'b0;
  logic [PW-1:0] umi_in_packet = '0;
  logic          umi_in_ready;
  logic          umi_out_valid;
  logic [PW-1:0] umi_out_packet;
  logic          umi_out_ready = 1'b0;
  logic [AW-1:0] loc_addr;
  logic          loc_write;
  logic          loc_read;
  logic [DW-1:0] loc_wrdata;
  logic [DW-1:0] loc_rddata = '0;
  logic          loc_ready = 1'b0;
  logic [15:0]   err_count;

  always #5 clk = ~clk;

  umi_endpoint #(
    .AW(AW),
    .PW(PW),
    .DW(DW),
    .RESP_OP(8'h02)
  ) dut (
    .clk           (clk),
    .nreset        (nreset),
    .umi_in_valid  (umi_in_valid),
    .umi_in_packet (umi_in_packet),
    .umi_in_ready  (umi_in_ready),
    .umi_out_valid (umi_out_valid),
    .umi_out_packet(umi_out_packet),
    .umi_out_ready (umi_out_ready),
    .loc_addr      (loc_addr),
    .loc_write     (loc_write),
    .loc_read      (loc_read),
    .loc_wrdata    (loc_wrdata),
    .loc_rddata    (loc_rddata),
    .loc_ready     (loc_ready),
    .err_count     (err_count)
  );

  typedef struct {
    logic [7:0]  op;
    logic [3:0]  size;
    logic [19:0] user;
    logic [63:0] dst;
    logic [63:0] src;
    logic [63:0] data;
    logic [63:0] rdata;
    logic [31:0] pad;
    int          lat;
    int          owait;
    bit          exp_rd;
    bit          exp_wr;
    bit          exp_resp;
    logic [63:0] exp_dfield;
  } vec_t;

  int nvec = 0;
  int nmis = 0;
  int exp_err = 0;

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] make_req(input vec_t v);
    logic [255:0] p;
    p = '0;
    p[7:0]     = v.op;
    p[11:8]    = v.size;
    p[31:12]   = v.user;
    p[63:32]   = v.dst[31:0];
    p[255:224] = v.dst[63:32];
    p[95:64]   = v.src[31:0];
    p[223:192] = v.src[63:32];
    p[159:96]  = v.data;
    p[191:160] = v.pad;
    return p;
  endfunction

  function automatic logic [255:0] make_rsp(input vec_t v);
    logic [255:0] p;
    p = '0;
    p[7:0]     = 8'h02;
    p[11:8]    = v.size;
    p[31:12]   = v.user;
    p[63:32]   = v.src[31:0];
    p[255:224] = v.src[63:32];
    p[95:64]   = v.dst[31:0];
    p[223:192] = v.dst[63:32];
    p[159:96]  = v.exp_dfield;
    return p;
  endfunction

  // Reference behaviour from the opcode alone.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    r = v;
    r.exp_rd     = (v.op == 8'h01);
    r.exp_wr     = (v.op == 8'h03) || (v.op == 8'h05);
    r.exp_resp   = (v.op == 8'h01) || (v.op == 8'h05);
    r.exp_dfield = (v.op == 8'h01) ? v.rdata : 64'h0;
    return r;
  endfunction

  function automatic vec_t mk(
    input logic [7:0] op, input logic [3:0] size, input logic [19:0] user,
    input logic [63:0] dst, input logic [63:0] src, input logic [63:0] data,
    input logic [63:0] rdata, input int lat, input int owait,
    input bit erd, input bit ewr, input bit ersp, input logic [63:0] edf);
    vec_t v;
    v.op = op; v.size = size; v.user = user;
    v.dst = dst; v.src = src; v.data = data;
    v.rdata = rdata; v.pad = 32'h0;
    v.lat = lat; v.owait = owait;
    v.exp_rd = erd; v.exp_wr = ewr;
    v.exp_resp = ersp; v.exp_dfield = edf;
    return v;
  endfunction

  function automatic logic [255:0] noise_pkt();
    logic [255:0] p;
    p = {8{$urandom}};
    p[7:0] = (($urandom % 2) == 0) ? 8'h01 : 8'h09;
    return p;
  endfunction

  // Apply one request at a negedge in IDLE and follow it to completion.
  task automatic run(input vec_t v);
    logic [255:0] ep;
    bit busy;
    busy = v.exp_rd | v.exp_wr;
    chk("idle_in_ready", umi_in_ready, 1);
    umi_in_valid  = 1'b1;
    umi_in_packet = make_req(v);
    @(negedge clk);
    umi_in_valid  = busy;
    umi_in_packet = noise_pkt();
    if (busy) begin
      for (int k = 0; k <= v.lat; k++) begin
        chk("loc_read", loc_read, v.exp_rd);
        chk("loc_write", loc_write, v.exp_wr);
        chk("loc_addr", loc_addr, v.dst);
        if (v.exp_wr) chk("loc_wrdata", loc_wrdata, v.data);
        chk("busy_in_ready", umi_in_ready, 0);
        chk("access_out_valid", umi_out_valid, 0);
        loc_ready     = (k == v.lat);
        loc_rddata    = (k == v.lat) ? v.rdata : {$urandom, $urandom};
        umi_out_ready = 1'($urandom % 2);
        @(negedge clk);
      end
      loc_ready     = 1'b0;
      umi_out_ready = 1'b0;
    end else begin
`ifdef UMI_ENDPOINT_ERRCNT_EN
      if (exp_err < 65535) exp_err++;
`endif
    end
    if (v.exp_resp) begin
      ep = make_rsp(v);
      for (int w = 0; w <= v.owait; w++) begin
        chk("out_valid", umi_out_valid, 1);
        chk("out_packet", umi_out_packet, ep);
        chk("resp_in_ready", umi_in_ready, 0);
        chk("resp_strobes", {loc_read, loc_write}, 0);
        umi_out_ready = (w == v.owait);
        @(negedge clk);
      end
      umi_out_ready = 1'b0;
    end
    umi_in_valid = 1'b0;
    chk("done_out_valid", umi_out_valid, 0);
    chk("done_in_ready", umi_in_ready, 1);
    chk("done_strobes", {loc_read, loc_write}, 0);
    chk("err_count", err_count, exp_err);
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_valid", umi_out_valid, 0);
    chk("rst_in_ready", umi_in_ready, 1);
    chk("rst_strobes", {loc_read, loc_write}, 0);
    chk("rst_err", err_count, 0);
    chk("rst_addr", loc_addr, 0);
    chk("rst_packet", umi_out_packet, 0);
    nreset = 1'b1;

    tbl.push_back(mk(8'h03, 4'h3, 20'h0, 64'h1000, 64'h0, 64'hA5A5,
                     64'h0, 0, 0, 0, 1, 0, 64'h0));
    tbl.push_back(mk(8'h01, 4'h2, 20'h12345, 64'h20,
                     64'h8000_0000_0000_0040, 64'h0, 64'h1234,
                     3, 0, 1, 0, 1, 64'h1234));
    tbl.push_back(mk(8'h01, 4'h1, 20'hFEDCB, 64'hDEAD_BEEF_0000_0100,
                     64'h0123_4567_89AB_CDEF, 64'h0,
                     64'hCAFE_F00D_1111_2222, 0, 5, 1, 0, 1,
                     64'hCAFE_F00D_1111_2222));
    tbl.push_back(mk(8'h05, 4'h3, 20'hABCDE, 64'h4000, 64'h77,
                     64'hFFFF_0000_FFFF_0000, 64'h5555, 1, 2,
                     0, 1, 1, 64'h0));
    tbl.push_back(mk(8'h09, 4'h0, 20'h1, 64'h8, 64'h9, 64'h1,
                     64'h0, 0, 0, 0, 0, 0, 64'h0));
    tbl.push_back(mk(8'h19, 4'h0, 20'h2, 64'h8, 64'h9, 64'h2,
                     64'h0, 0, 0, 0, 0, 0, 64'h0));
    tbl.push_back(mk(8'h29, 4'h0, 20'h3, 64'h8, 64'h9, 64'h3,
                     64'h0, 0, 0, 0, 0, 0, 64'h0));
    tbl.push_back(mk(8'h00, 4'h0, 20'h0, 64'h0, 64'h0, 64'h0,
                     64'h0, 0, 0, 0, 0, 0, 64'h0));
    tbl.push_back(mk(8'h7F, 4'h0, 20'h0, 64'h0, 64'h0, 64'h0,
                     64'h0, 0, 0, 0, 0, 0, 64'h0));
    foreach (tbl[i]) run(tbl[i]);

    // Reset while a read waits on the local bus.
    umi_in_valid  = 1'b1;
    umi_in_packet = make_req(model(mk(8'h01, 4'h0, 20'h0, 64'h40,
                     64'h50, 64'h0, 64'h0, 0, 0, 0, 0, 0, 64'h0)));
    @(negedge clk);
    umi_in_valid = 1'b0;
    chk("pre_rst_loc_read", loc_read, 1);
    nreset = 1'b0;
    @(negedge clk);
    exp_err = 0;
    chk("arst_strobes", {loc_read, loc_write}, 0);
    chk("arst_out_valid", umi_out_valid, 0);
    chk("arst_in_ready", umi_in_ready, 1);
    chk("arst_err", err_count, exp_err);
    nreset    = 1'b1;
    loc_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("arst_no_resp", umi_out_valid, 0);
      chk("arst_no_read", loc_read, 0);
    end
    loc_ready = 1'b0;

    // Reset while a response is pending.
    umi_in_valid  = 1'b1;
    umi_in_packet = make_req(model(mk(8'h01, 4'h0, 20'h0, 64'h44,
                     64'h54, 64'h0, 64'h0, 0, 0, 0, 0, 0, 64'h0)));
    @(negedge clk);
    umi_in_valid = 1'b0;
    loc_ready    = 1'b1;
    @(negedge clk);
    loc_ready = 1'b0;
    chk("pre_rst_out_valid", umi_out_valid, 1);
    nreset = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    chk("rrst_out_valid", umi_out_valid, 0);
    chk("rrst_in_ready", umi_in_ready, 1);

    for (int n = 0; n < 150; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      rv.op = (sel < 3) ? 8'h01 :
              (sel < 5) ? 8'h03 :
              (sel < 7) ? 8'h05 :
              (sel == 7) ? {4'($urandom), 4'h9} :
              (sel == 8) ? 8'h00 : 8'($urandom);
      rv.size  = 4'($urandom);
      rv.user  = 20'($urandom);
      rv.dst   = {$urandom, $urandom};
      rv.src   = {$urandom, $urandom};
      rv.data  = {$urandom, $urandom};
      rv.rdata = {$urandom, $urandom};
      rv.pad   = $urandom;
      rv.lat   = $urandom_range(0, 3);
      rv.owait = $urandom_range(0, 3);
      run(model(rv));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
